// File: rtl/dac_spi_pkg.sv
// ----------------------------------------------------------------------------
// dac_spi_pkg
//   Shared definitions for the 24-bit DAC SPI write frame. The frame layout is
//   {cmd[3:0], code[15:0], pad[3:0]} sent MSB first. The DAC SPI master and the
//   dac_spi_rx receiver both import this package, so the frame layout is
//   defined in one place only.
//
//   Contents:
//     FRAME_WIDTH / CODE_WIDTH / CMD_WIDTH / PAD_WIDTH  frame field widths
//     CNT_WIDTH         width of a bit counter that can hold FRAME_WIDTH
//     CMD_WRITE_UPDATE  command that writes and updates the DAC output
//     err_code_e        receiver error causes
//     rx_state_e        receiver FSM states
//     dac_frame_t       packed view of one frame
//     pack_frame()      builds a frame with zero padding
// ----------------------------------------------------------------------------
package dac_spi_pkg;

    localparam int FRAME_WIDTH = 24;
    localparam int CODE_WIDTH  = 16;
    localparam int CMD_WIDTH   = 4;
    localparam int PAD_WIDTH   = 4;
    localparam int CNT_WIDTH   = $clog2(FRAME_WIDTH + 1);

    localparam logic [CMD_WIDTH-1:0] CMD_WRITE_UPDATE = 4'b0011;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_SHORT = 2'd1,
        ERR_LONG  = 2'd2,
        ERR_PAD   = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        RECV,
        OVERRUN
    } rx_state_e;

    typedef struct packed {
        logic [CMD_WIDTH-1:0]  cmd;
        logic [CODE_WIDTH-1:0] code;
        logic [PAD_WIDTH-1:0]  pad;
    } dac_frame_t;

    function automatic dac_frame_t pack_frame(input logic [CMD_WIDTH-1:0]  cmd,
                                              input logic [CODE_WIDTH-1:0] code);
        dac_frame_t f;
        f.cmd  = cmd;
        f.code = code;
        f.pad  = '0;
        return f;
    endfunction

endpackage

// File: rtl/dac_spi_rx_if.sv
// ----------------------------------------------------------------------------
// dac_spi_rx_if
//   Bundles the SPI lines and the frame/status outputs of dac_spi_rx.
//
//   SPI side      : sync_i (active-low frame select), sclk_i, sdi_i (MSB first)
//   Frame outputs : frame_vld_o, frame_err_o, err_code_o, cmd_o, code_o
//   Status        : dac_code_o, busy_o, frame_cnt_o
//
//   Modports:
//     master - drives the SPI lines, observes the receiver outputs
//     slave  - the receiver itself
// ----------------------------------------------------------------------------
interface dac_spi_rx_if;

    logic                              sync_i;
    logic                              sclk_i;
    logic                              sdi_i;

    logic                              frame_vld_o;
    logic                              frame_err_o;
    dac_spi_pkg::err_code_e            err_code_o;
    logic [dac_spi_pkg::CMD_WIDTH-1:0]  cmd_o;
    logic [dac_spi_pkg::CODE_WIDTH-1:0] code_o;
    logic [dac_spi_pkg::CODE_WIDTH-1:0] dac_code_o;
    logic                              busy_o;
    logic [15:0]                       frame_cnt_o;

    modport master (
        output sync_i, sclk_i, sdi_i,
        input  frame_vld_o, frame_err_o, err_code_o, cmd_o, code_o,
               dac_code_o, busy_o, frame_cnt_o
    );

    modport slave (
        input  sync_i, sclk_i, sdi_i,
        output frame_vld_o, frame_err_o, err_code_o, cmd_o, code_o,
               dac_code_o, busy_o, frame_cnt_o
    );

endinterface

// File: rtl/dac_spi_rx_sig_sync_edge.sv
// ----------------------------------------------------------------------------
// sig_sync_edge
//   STAGES-deep flip-flop synchronizer followed by an edge detector.
//
//   Ports:
//     clk_i    oversampling clock
//     arst_ni  asynchronous active-low reset
//     sig_i    asynchronous input
//     level_o  synchronized level
//     rise_o   one-cycle pulse on a synchronized 0->1 transition
//     fall_o   one-cycle pulse on a synchronized 1->0 transition
//
//   All flops reset to 0. For the frame select this matters: a sync line that
//   is low at reset release reads as low, so the receiver stays in WAIT_IDLE
//   instead of mistaking the tail of an interrupted frame for a new one.
//   STAGES must be at least 2.
// ----------------------------------------------------------------------------
module sig_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbour and the chain shifts by one.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/dac_spi_rx.sv
// ----------------------------------------------------------------------------
// dac_spi_rx
//   SPI slave receiver for 24-bit DAC write frames. sync/sclk/sdi are
//   oversampled on clk_i, deserialized, and each frame is validated when sync
//   returns high. A valid frame with CMD_WRITE_UPDATE loads the DAC code.
//
//   Ports:
//     clk_i    oversampling clock (sclk period >= 4 clk_i periods)
//     arst_ni  asynchronous active-low reset
//     bus      dac_spi_rx_if.slave:
//                sync_i, sclk_i, sdi_i          SPI inputs
//                frame_vld_o / frame_err_o      one-cycle result pulses
//                err_code_o                     error cause, valid with frame_err_o
//                cmd_o, code_o                  fields of the last valid frame
//                dac_code_o                     current DAC output code
//                busy_o                         frame in progress
//                frame_cnt_o                    saturating valid-frame count
//
//   Parameters:
//     SYNC_STAGES     synchronizer depth (>= 2)
//     DEFAULT_CODE    reset value of dac_code_o
//     SAMPLE_FALLING  1: sample sdi on sclk fall, 0: on sclk rise
// ----------------------------------------------------------------------------
module dac_spi_rx
    import dac_spi_pkg::*;
#(
    parameter int                    SYNC_STAGES    = 2,
    parameter logic [CODE_WIDTH-1:0] DEFAULT_CODE   = 16'h0000,
    parameter bit                    SAMPLE_FALLING = 1'b1
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    dac_spi_rx_if.slave  bus
);

    // ------------------------------------------------------------------
    // Synchronizers: identical depth on all three lines keeps sdi aligned
    // with the sclk edge that samples it.
    // ------------------------------------------------------------------
    logic sync_lvl, sync_rise, sync_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

    sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sync (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .sig_i   (bus.sync_i),
        .level_o (sync_lvl),
        .rise_o  (sync_rise),
        .fall_o  (sync_fall)
    );

    sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .sig_i   (bus.sclk_i),
        .level_o (sclk_lvl_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .sig_i   (bus.sdi_i),
        .level_o (sdi_lvl),
        .rise_o  (sdi_rise_unused),
        .fall_o  (sdi_fall_unused)
    );

    logic sample_edge;
    assign sample_edge = SAMPLE_FALLING ? sclk_fall : sclk_rise;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rx_state_e               state_q,     state_d;
    logic [CNT_WIDTH-1:0]    cnt_q,       cnt_d;
    logic [FRAME_WIDTH-1:0]  shreg_q,     shreg_d;
    logic                    vld_q,       vld_d;
    logic                    err_q,       err_d;
    err_code_e               err_code_q,  err_code_d;
    logic [CMD_WIDTH-1:0]    cmd_q,       cmd_d;
    logic [CODE_WIDTH-1:0]   code_q,      code_d;
    logic [CODE_WIDTH-1:0]   dac_code_q,  dac_code_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;

    dac_frame_t rx_frame;
    assign rx_frame = shreg_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            cmd_q       <= '0;
            code_q      <= '0;
            dac_code_q  <= DEFAULT_CODE;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cmd_q       <= cmd_d;
            code_q      <= code_d;
            dac_code_q  <= dac_code_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        vld_d       = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        cmd_d       = cmd_q;
        code_d      = code_q;
        dac_code_d  = dac_code_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            // Wait for sync high so a frame interrupted by reset is not
            // picked up halfway through.
            WAIT_IDLE: begin
                if (sync_lvl) begin
                    state_d = IDLE;
                end
            end

            // A sample edge coinciding with the sync fall is dropped simply
            // because this state never looks at it.
            IDLE: begin
                if (sync_fall) begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = RECV;
                end
            end

            // Sync rise takes priority over a coincident sample edge.
            RECV: begin
                if (sync_rise) begin
                    state_d = IDLE;
                    if (cnt_q == '0) begin
                        // Select toggled without clocks: not a frame at all.
                    end else if (cnt_q != CNT_WIDTH'(FRAME_WIDTH)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_SHORT;
                    end else if (rx_frame.pad != '0) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_PAD;
                    end else begin
                        vld_d  = 1'b1;
                        cmd_d  = rx_frame.cmd;
                        code_d = rx_frame.code;
                        if (frame_cnt_q != '1) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                        if (rx_frame.cmd == CMD_WRITE_UPDATE) begin
                            dac_code_d = rx_frame.code;
                        end
                    end
                end else if (sample_edge) begin
                    if (cnt_q == CNT_WIDTH'(FRAME_WIDTH)) begin
                        state_d = OVERRUN;
                    end else begin
                        shreg_d = {shreg_q[FRAME_WIDTH-2:0], sdi_lvl};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end

            OVERRUN: begin
                if (sync_rise) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_LONG;
                    state_d    = IDLE;
                end
            end

            default: state_d = WAIT_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.frame_vld_o = vld_q;
    assign bus.frame_err_o = err_q;
    assign bus.err_code_o  = err_code_q;
    assign bus.cmd_o       = cmd_q;
    assign bus.code_o      = code_q;
    assign bus.dac_code_o  = dac_code_q;
    assign bus.frame_cnt_o = frame_cnt_q;
    assign bus.busy_o      = (state_q == RECV) || (state_q == OVERRUN);

endmodule

// File: tb/tb_dac_spi_rx.sv
// ----------------------------------------------------------------------------
// tb_dac_spi_rx
//   Directed bench for dac_spi_rx. The stimulus process drives SPI frames and
//   pushes the expected result of each one into a scoreboard queue; a monitor
//   pops and compares whenever the receiver raises frame_vld_o/frame_err_o.
// ----------------------------------------------------------------------------
module tb_dac_spi_rx;
    import dac_spi_pkg::*;

    typedef struct {
        bit          is_err;
        logic [1:0]  err_code;
        logic [3:0]  cmd;
        logic [15:0] code;
        logic [15:0] dac;
        logic [15:0] cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dac_spi_rx_if bus ();

    dac_spi_rx #(
        .SYNC_STAGES    (2),
        .DEFAULT_CODE   (16'h0000),
        .SAMPLE_FALLING (1'b1)
    ) dut (
        .clk_i   (clk),
        .arst_ni (rst_n),
        .bus     (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    // Reference model of the receiver's architectural outputs.
    logic [3:0]  m_cmd  = '0;
    logic [15:0] m_code = '0;
    logic [15:0] m_dac  = '0;
    logic [15:0] m_cnt  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cmd  = '0;
        m_code = '0;
        m_dac  = 16'h0000;
        m_cnt  = '0;
    endtask

    task automatic push_valid(input logic [23:0] f);
        exp_t e;
        m_cmd  = f[23:20];
        m_code = f[19:4];
        if (m_cmd == 4'b0011) m_dac = m_code;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        e.is_err = 1'b0; e.err_code = 2'd0;
        e.cmd = m_cmd; e.code = m_code; e.dac = m_dac; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.err_code = code;
        e.cmd = m_cmd; e.code = m_code; e.dac = m_dac; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Drive one frame: data bits [nbits-1:0], MSB first. sdi changes with the
    // sclk rising edge and is sampled by the receiver on the falling edge.
    task automatic send_frame(input logic [31:0] data, input int nbits,
                              input int half, input int gap);
        @(negedge clk);
        bus.sync_i = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.sdi_i  = data[i];
            bus.sclk_i = 1'b1;
            repeat (half) @(negedge clk);
            bus.sclk_i = 1'b0;
            repeat (half) @(negedge clk);
        end
        bus.sync_i = 1'b1;
        bus.sdi_i  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Bounded wait for all expected pulses to have been seen.
    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(tag, sb.size(), 0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_dac"}, bus.dac_code_o, m_dac);
        check({tag, "_cnt"}, bus.frame_cnt_o, m_cnt);
        check({tag, "_cmd"}, bus.cmd_o, m_cmd);
        check({tag, "_code"}, bus.code_o, m_code);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.frame_vld_o === 1'b1 || bus.frame_err_o === 1'b1)) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", {30'b0, bus.frame_vld_o, bus.frame_err_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_vld", bus.frame_vld_o, !e.is_err);
                check("pulse_err", bus.frame_err_o, e.is_err);
                if (e.is_err) check("err_code", bus.err_code_o, e.err_code);
                check("pulse_cmd", bus.cmd_o, e.cmd);
                check("pulse_code", bus.code_o, e.code);
                check("pulse_dac", bus.dac_code_o, e.dac);
                check("pulse_cnt", bus.frame_cnt_o, e.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rnd;
        logic [31:0] f;

        bus.sync_i = 1'b1;
        bus.sclk_i = 1'b0;
        bus.sdi_i  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_vld",  bus.frame_vld_o, 1'b0);
        check("rst_err",  bus.frame_err_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_err_code", bus.err_code_o, 2'd0);
        check_state("rst");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Write/update frame at sclk = clk/6
        push_valid(24'h312340);
        send_frame(32'h312340, 24, 3, 6);
        drain("drain_f1");
        check_state("f1");
        check("f1_dac_abs", bus.dac_code_o, 16'h1234);

        // Non-update command: dac_code_o keeps the previous value
        push_valid(24'h1ABCD0);
        send_frame(32'h1ABCD0, 24, 3, 6);
        drain("drain_f2");
        check_state("f2");
        check("f2_dac_abs", bus.dac_code_o, 16'h1234);

        // Short, long and bad-padding frames
        push_err(2'd1);
        send_frame(32'h312340, 23, 3, 6);
        drain("drain_short");
        push_err(2'd2);
        send_frame(32'h0312340, 25, 3, 6);
        drain("drain_long");
        push_err(2'd3);
        send_frame(32'h312341, 24, 3, 6);
        drain("drain_pad");
        check_state("after_err");

        // Select pulse with no sclk edges
        @(negedge clk);
        bus.sync_i = 1'b0;
        repeat (6) @(negedge clk);
        check("empty_busy_hi", bus.busy_o, 1'b1);
        bus.sync_i = 1'b1;
        repeat (8) @(negedge clk);
        check("empty_busy_lo", bus.busy_o, 1'b0);
        drain("drain_empty");
        check_state("empty");

        // Reset after bit 10 with sync held low; rest of frame must be ignored
        f = 32'h3FFFF0;
        @(negedge clk);
        bus.sync_i = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 23; i >= 14; i--) begin
            bus.sdi_i = f[i]; bus.sclk_i = 1'b1; repeat (3) @(negedge clk);
            bus.sclk_i = 1'b0; repeat (3) @(negedge clk);
        end
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("midrst_busy", bus.busy_o, 1'b0);
        check_state("midrst");
        rst_n = 1'b1;
        for (int i = 13; i >= 0; i--) begin
            bus.sdi_i = f[i]; bus.sclk_i = 1'b1; repeat (3) @(negedge clk);
            bus.sclk_i = 1'b0; repeat (3) @(negedge clk);
        end
        bus.sync_i = 1'b1;
        bus.sdi_i  = 1'b0;
        repeat (10) @(negedge clk);
        drain("drain_midrst");
        check_state("after_midrst");
        push_valid(24'h300010);
        send_frame(32'h300010, 24, 3, 6);
        drain("drain_post_rst");
        check("post_rst_dac", bus.dac_code_o, 16'h0001);
        check_state("post_rst");

        // Master-style loopback: 100 random codes back to back
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        rnd = '0;
        for (int n = 0; n < 100; n++) begin
            rnd = 16'($urandom);
            push_valid(pack_frame(CMD_WRITE_UPDATE, rnd));
            send_frame({8'h00, pack_frame(CMD_WRITE_UPDATE, rnd)}, 24, 3, 3);
        end
        drain("drain_loop");
        check("loop_cnt", bus.frame_cnt_o, 16'd100);
        check("loop_dac", bus.dac_code_o, rnd);
        check_state("loop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_spi_rx.md
Name: dac_spi_rx

Overview:
- SPI receiver (slave end) for the 24-bit DAC write frames produced by the DAC SPI master. Accepts sync/sclk/sdi, deserializes and validates each frame, and holds the last written DAC code.
- Runs on an oversampling clock. Used as the in-fabric DAC model for loopback self-test and as the SPI monitor in the measurement subsystem.

Parameters:
- SYNC_STAGES, 2, flip-flop stages for the sync_i, sclk_i and sdi_i synchronizers (≥2).
- DEFAULT_CODE, 16'h0000, reset value of dac_code_o.
- SAMPLE_FALLING, 1, 1 = sample sdi on sclk falling edge, 0 = rising edge.

Ports:
- clk_i  in  1  oversampling clock; sclk_i period ≥ 4 clk_i periods.
- arst_ni  in  1  asynchronous active-low reset.
- sync_i  in  1  frame select, active low.
- sclk_i  in  1  serial clock.
- sdi_i  in  1  serial data, MSB first.
- frame_vld_o  out  1  one-cycle pulse: well-formed frame received.
- frame_err_o  out  1  one-cycle pulse: malformed frame.
- err_code_o  out  2  error cause, valid with frame_err_o: 1 = short, 2 = long, 3 = nonzero padding.
- cmd_o  out  4  frame bits [23:20]; valid with frame_vld_o, held until next valid frame.
- code_o  out  16  frame bits [19:4]; same validity rule as cmd_o.
- dac_code_o  out  16  current DAC output code; updated only by a valid frame with cmd 4'b0011.
- busy_o  out  1  high while a frame is in progress.
- frame_cnt_o  out  16  count of valid frames, saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - frame_vld_o, frame_err_o, busy_o = 0.
  - err_code_o, cmd_o, code_o, frame_cnt_o = 0.
  - dac_code_o = DEFAULT_CODE.
  - state = WAIT_IDLE.
- Synchronization:
  - sync_i, sclk_i and sdi_i pass through identical SYNC_STAGES synchronizers, so sdi stays aligned to sclk.
  - Edges are detected on the synchronized signals.
- State machine:
  - WAIT_IDLE: go to IDLE when synchronized sync is high. This blocks frames already in progress at reset release or after a reset mid-frame.
  - IDLE: on sync falling edge, clear the 24-bit shift register and 5-bit bit counter, then go to RECV.
  - RECV: on each sample edge, shift sdi into the LSB and increment the counter. When the counter is already 24 and another sample edge arrives, go to OVERRUN. On sync rising edge, evaluate.
  - OVERRUN: ignore edges. On sync rising edge, raise the long-frame error and go to IDLE.
- Evaluation on sync rise in RECV:
  - Counter = 0: silently ignored; no pulse, no count.
  - Counter 1..23: error 1 (short).
  - Counter = 24 and bits [3:0] ≠ 0: error 3 (padding).
  - Otherwise: frame valid.
    - Latch cmd_o and code_o.
    - Increment frame_cnt_o unless saturated.
    - If cmd = 4'b0011, load dac_code_o with code in the same cycle.
  - Next state is IDLE.
- Timing:
  - The frame_vld_o / frame_err_o pulse is exactly 1 cycle, registered, one clk_i after the cycle in which the synchronized sync rising edge is detected.
  - dac_code_o, cmd_o and code_o change on that same edge.
- busy_o = 1 in RECV and OVERRUN.
- Simultaneous events:
  - Sync rise and sample edge in the same cycle: sync wins, the edge is discarded.
  - Sync fall and sample edge in the same cycle: the edge is discarded.
  - A sync fall in the cycle after an evaluation is accepted normally; back-to-back frames are supported.
- Error frames never modify cmd_o, code_o, dac_code_o or frame_cnt_o.
- Reset asserted mid-frame: all state is cleared immediately. After release, the remainder of that frame is ignored via WAIT_IDLE.

Decomposition:
- Package dac_spi_pkg holds:
  - FRAME_WIDTH = 24, CODE_WIDTH = 16, CMD_WIDTH = 4, PAD_WIDTH = 4.
  - CMD_WRITE_UPDATE = 4'b0011.
  - err_code_e enum (ERR_NONE, ERR_SHORT, ERR_LONG, ERR_PAD).
  - rx_state_e enum (WAIT_IDLE, IDLE, RECV, OVERRUN).
  - The DAC SPI master shares this package for frame assembly.
- Sub-module sig_sync_edge: N-stage synchronizer with rise/fall pulse outputs. Three instances: sync, sclk, sdi (sdi edge outputs unused).

Test Plan:
- Frame 24'h312340 sent with sclk at clk/6 -> frame_vld_o pulse; cmd_o = 4'h3; code_o = 16'h1234; dac_code_o = 16'h1234; frame_cnt_o = 1; no err.
- Frame 24'h1ABCD0 (cmd 1) -> frame_vld_o; cmd_o = 4'h1; code_o = 16'hABCD; dac_code_o unchanged from previous value.
- 23-bit frame -> frame_err_o, err_code_o = 1. 25-bit frame -> frame_err_o, err_code_o = 2. 24'h312341 -> err_code_o = 3. In all cases dac_code_o and frame_cnt_o unchanged.
- Reset pulsed after bit 10 of 24'h3FFFF0 with sync held low -> after release no pulse for that frame; next frame 24'h300010 -> dac_code_o = 16'h0001.
- Loopback from the DAC SPI master (CLK_DIV 3, WAIT_CYCLES 3), 100 random codes back-to-back -> each code appears on dac_code_o in order; frame_cnt_o = 100; zero errors.
- Sync pulsed low then high with no sclk edges -> no pulse; counter and outputs unchanged.
